countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the load value and the count.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port enable, input, 1 bit: when 1 in RUN, the count decrements.
REQ-005 SHALL have port abort, input, 1 bit: cancels a run in progress.
REQ-006 SHALL have port load_valid, input, 1 bit: a load request is present.
REQ-007 SHALL have port load_value, input, WIDTH bits: start value, sampled at the handshake.
REQ-008 SHALL have port load_ready, output, 1 bit: timer can accept a load.
REQ-009 SHALL have port count, output, WIDTH bits: current remaining count.
REQ-010 SHALL have port busy, output, 1 bit: 1 while in RUN.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the count expires.

Function
REQ-012 SHALL implement a two-state machine with states IDLE and RUN.
REQ-013 SHALL drive load_ready=1 only in IDLE; it is a combinational decode of state.
REQ-014 SHALL accept a load on a cycle where load_valid=1 and load_ready=1: count<=load_value and reload_reg<=load_value.
REQ-015 SHALL, on a load with load_value!=0, go to RUN in the next cycle.
REQ-016 SHALL, on a load with load_value==0, stay in IDLE and pulse done in the next cycle.
REQ-017 SHALL, in RUN with enable=1 and abort=0, set count<=count-1 each cycle.
REQ-018 SHALL, in RUN with enable=0, hold count with no timeout.
REQ-019 SHALL, when count==1 with enable=1 in RUN, set count<=0 and done=1 for exactly one cycle, coincident with count reading 0.
REQ-020 SHALL return to IDLE on that expiry edge when auto-reload is absent.
REQ-021 SHALL give abort priority over enable: abort=1 in RUN sets count<=0 and goes to IDLE, with no done pulse.
REQ-022 SHALL ignore abort in IDLE.
REQ-023 SHALL ignore load_valid in RUN; the requester holds load_valid until it sees load_ready.
REQ-024 SHALL not wrap: count never decrements below 0.
REQ-025 SHALL drive done from a register (registered, glitch-free).

Reset
REQ-026 SHALL, on reset_n=0, immediately set state=IDLE, count=0, reload_reg=0, done=0 and busy=0, with load_ready=1.
REQ-027 SHALL abandon a run in progress when reset is asserted mid-run, with no done pulse.
REQ-028 SHALL be able to accept a load on the first clk edge after reset_n rises.

Configuration
REQ-029 SHALL use macro COUNTDOWN_TIMER_AUTORELOAD_EN.
REQ-030 SHALL, with the macro defined, on expiry in RUN: set count<=reload_reg, stay in RUN, and still pulse done; only abort or reset returns to IDLE.
REQ-031 SHALL, without the macro, behave per REQ-020 and synthesize no logic for reload_reg.

Structure
REQ-032 SHALL define the state enum (IDLE, RUN) and the default WIDTH constant in shared package countdown_timer_pkg.
REQ-033 SHALL be a single module with no sub-module.

Verification
REQ-034 SHALL cover: reset, load 5, enable held at 1 -> count 5,4,3,2,1,0; done high only in the cycle count=0; then IDLE with load_ready=1.
REQ-035 SHALL cover: load 3, enable toggled 1,0,0,1,1 -> count 3,2,2,2,1,0; done pulses once.
REQ-036 SHALL cover: load 200, abort asserted at count=150 with enable=1 -> count=0, IDLE, no done.
REQ-037 SHALL cover: load 0 -> state stays IDLE; done pulses one cycle after the handshake; busy stays 0.
REQ-038 SHALL cover: load_valid held with value 9 during RUN -> not accepted; accepted on the first IDLE cycle after expiry.
REQ-039 SHALL cover, with COUNTDOWN_TIMER_AUTORELOAD_EN defined: load 2, enable=1 for 7 cycles -> count 2,1,0→2,1,0→2; done pulses twice; busy stays 1; reset_n pulsed low mid-run -> count=0 and IDLE immediately.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
package countdown_timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle registered expiry pulse.
// Optional feature macro: COUNTDOWN_TIMER_AUTORELOAD_EN. When it is defined,
// expiry restarts the count from the last loaded value and the timer stays in
// RUN until abort or reset. Without it, the timer returns to IDLE on expiry and
// no reload register is built.
//
// state | meaning
// IDLE  | waiting for a load; load_ready=1
// RUN   | counting down while enable=1; abort or expiry leaves
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             abort,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // Next-state, next-count and expiry pulse.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    count_d = load_value;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                    reload_d = load_value;
`endif
                    // A zero load expires at once without ever entering RUN.
                    if (load_value == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (enable) begin
                    if (count_q == WIDTH'(1)) begin
                        count_d = '0;
                        done_d  = 1'b1;
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
                        state_d = IDLE;
`endif
                    end else if (count_q == '0) begin
                        // Count shows 0 for one cycle after expiry before
                        // restarting; without reload this point is unreachable
                        // and simply parks the timer.
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                        count_d = reload_q;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, count and pulse registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    // Last accepted load value, restored on each expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign count      = count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic         abort;
    logic         load_valid;
    logic [W-1:0] load_value;
    logic         load_ready;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .abort      (abort),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        abort      = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        #2;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: count=%0d busy=%b done=%b ready=%b, want 0 0 0 1",
                     count, busy, done, load_ready);
        end
        #2;
        step();
        #2;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_load5();
        logic [W-1:0] exp_cnt [6];
        exp_cnt = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        load_valid = 1'b1;
        load_value = 8'd5;
        enable     = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            checks++;
            if (count !== exp_cnt[i] || done !== (i == 5)) begin
                failures++;
                $display("FAIL load5 step %0d: count=%0d done=%b, want %0d %b",
                         i, count, done, exp_cnt[i], (i == 5));
            end
        end
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL load5 idle: busy=%b ready=%b, want 0 1", busy, load_ready);
        end
        step();
        checks++;
        if (done !== 1'b0 || count !== 8'd0) begin
            failures++;
            $display("FAIL load5 after: done=%b count=%0d, want 0 0", done, count);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_toggle();
        logic         en_seq  [5];
        logic [W-1:0] exp_cnt [5];
        int           pulses;
        en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_cnt = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd0};
        pulses  = 0;
        load_valid = 1'b1;
        load_value = 8'd3;
        enable     = 1'b0;
        step();
        load_valid = 1'b0;
        checks++;
        if (count !== 8'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL toggle load: count=%0d busy=%b, want 3 1", count, busy);
        end
        for (int i = 0; i < 5; i++) begin
            enable = en_seq[i];
            step();
            if (done === 1'b1) pulses++;
            checks++;
            if (count !== exp_cnt[i]) begin
                failures++;
                $display("FAIL toggle step %0d: count=%0d, want %0d", i, count, exp_cnt[i]);
            end
        end
        enable = 1'b0;
        step();
        if (done === 1'b1) pulses++;
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL toggle pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_abort();
        int pulses;
        pulses = 0;
        load_valid = 1'b1;
        load_value = 8'd200;
        enable     = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (count !== 8'd150) begin
            failures++;
            $display("FAIL abort pre: count=%0d, want 150", count);
        end
        abort = 1'b1;
        step();
        if (done === 1'b1) pulses++;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort: count=%0d busy=%b ready=%b, want 0 0 1", count, busy, load_ready);
        end
        abort = 1'b0;
        step();
        if (done === 1'b1) pulses++;
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL abort done: pulses=%0d, want 0", pulses);
        end
        enable = 1'b0;
    endtask

    task automatic test_load_zero();
        load_valid = 1'b1;
        load_value = 8'd0;
        enable     = 1'b1;
        step();
        load_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b1 || count !== 8'd0) begin
            failures++;
            $display("FAIL load0 pulse: done=%b busy=%b ready=%b count=%0d, want 1 0 1 0",
                     done, busy, load_ready, count);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL load0 after: done=%b busy=%b, want 0 0", done, busy);
        end
        enable = 1'b0;
    endtask

    task automatic test_hold_valid();
        load_valid = 1'b1;
        load_value = 8'd2;
        enable     = 1'b1;
        step();
        load_value = 8'd9;
        step();
        checks++;
        if (count !== 8'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold run: count=%0d busy=%b, want 1 1", count, busy);
        end
        step();
        checks++;
        if (count !== 8'd0 || done !== 1'b1 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold expire: count=%0d done=%b ready=%b, want 0 1 1",
                     count, done, load_ready);
        end
        step();
        load_valid = 1'b0;
        checks++;
        if (count !== 8'd9 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL hold accept: count=%0d busy=%b done=%b, want 9 1 0", count, busy, done);
        end
        enable = 1'b0;
        abort  = 1'b1;
        step();
        abort  = 1'b0;
    endtask

    task automatic test_abort_idle();
        abort      = 1'b1;
        load_valid = 1'b1;
        load_value = 8'd4;
        step();
        load_valid = 1'b0;
        checks++;
        if (count !== 8'd4 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort idle: count=%0d busy=%b, want 4 1", count, busy);
        end
        step();
        abort = 1'b0;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort run: count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_reset_midrun();
        load_valid = 1'b1;
        load_value = 8'd10;
        enable     = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset midrun: count=%0d busy=%b done=%b ready=%b, want 0 0 0 1",
                     count, busy, done, load_ready);
        end
        #2;
        reset_n    = 1'b1;
        load_valid = 1'b1;
        load_value = 8'd7;
        step();
        load_valid = 1'b0;
        checks++;
        if (count !== 8'd7 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first load: count=%0d busy=%b, want 7 1", count, busy);
        end
        enable = 1'b0;
        abort  = 1'b1;
        step();
        abort  = 1'b0;
    endtask

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    task automatic test_autoreload();
        logic [W-1:0] exp_cnt [6];
        int           pulses;
        exp_cnt = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2};
        pulses  = 0;
        load_valid = 1'b1;
        load_value = 8'd2;
        enable     = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) pulses++;
            checks++;
            if (count !== exp_cnt[i] || busy !== 1'b1 || done !== (exp_cnt[i] == 8'd0)) begin
                failures++;
                $display("FAIL autoreload step %0d: count=%0d busy=%b done=%b, want %0d 1 %b",
                         i, count, busy, done, exp_cnt[i], (exp_cnt[i] == 8'd0));
            end
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL autoreload pulses: got %0d, want 2", pulses);
        end
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL autoreload reset: count=%0d busy=%b ready=%b, want 0 0 1",
                     count, busy, load_ready);
        end
        #2;
        reset_n = 1'b1;
        enable  = 1'b0;
        step();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load5();
        test_enable_toggle();
        test_abort();
        test_load_zero();
        test_hold_valid();
        test_abort_idle();
        test_reset_midrun();
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
